i2c_init_sequencer: RTL and testbench

Sequences a table of I2C register writes through the single-byte I2C write engine, for example to bring up a sensor or codec after power-on. It fetches {address, register, data} entries from an external synchronous table and drives the engine's active-low enable_send handshake. It checks the engine's ack status for each entry, retries NACKed writes, and reports done or error to the system. The sequencer runs in the engine's clock domain.

---
 rtl/i2c_pkg.sv | 36 +++
 rtl/i2c_seq_timer.sv | 30 +++
 rtl/i2c_init_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_i2c_init_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared constants for the I2C init sequencer: status masks, table markers, FSM states.
// States DELAY/NEXT exist only when I2C_SEQ_DELAY_EN is defined.
package i2c_pkg;

   localparam logic [7:0] ADDR_NACK = 8'h01;
   localparam logic [7:0] ADDR_ACK  = 8'h02;
   localparam logic [7:0] REG_NACK  = 8'h04;
   localparam logic [7:0] REG_ACK   = 8'h08;
   localparam logic [7:0] DATA_NACK = 8'h10;
   localparam logic [7:0] DATA_ACK  = 8'h20;
   localparam logic [7:0] ALL_ACK   = ADDR_ACK | REG_ACK | DATA_ACK;

   localparam logic [7:0] END_MARK   = 8'hFF;
   localparam logic [7:0] DELAY_MARK = 8'hFE;

   // Engine i2c_busy is inverted: high means idle.
   localparam logic I2C_NOT_BUSY = 1'b1;
   localparam logic I2C_BUSY     = 1'b0;

`ifdef I2C_SEQ_DELAY_EN
   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_LOAD, S_REQ, S_WAIT_BUSY, S_WAIT_DONE,
      S_RELEASE, S_CHECK, S_DONE, S_ERROR, S_DELAY, S_NEXT
   } seq_state_e;
`else
   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_LOAD, S_REQ, S_WAIT_BUSY, S_WAIT_DONE,
      S_RELEASE, S_CHECK, S_DONE, S_ERROR
   } seq_state_e;
`endif

   function automatic logic is_all_ack(input logic [7:0] status);
      return status == ALL_ACK;
   endfunction

endpackage

// File: rtl/i2c_seq_timer.sv
// Loadable saturating down-counter; zero is high once the count has run out.
module i2c_seq_timer #(
   parameter int CW = 8
) (
   input  logic          clock_i2c,
   input  logic          reset,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          dec,
   output logic          zero
);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (dec && (cnt_q != '0))
         cnt_d = cnt_q - CW'(1);
   end

   always_ff @(posedge clock_i2c) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/i2c_init_sequencer.sv
// Walks a table of {addr,reg,data} writes through the single-byte I2C engine with retry/timeout.
// Define I2C_SEQ_DELAY_EN to treat addr 8'hFE entries as data*DELAY_UNIT cycle delays.
module i2c_init_sequencer
   import i2c_pkg::*;
#(
   parameter int TBL_AW     = 6,
   parameter int MAX_RETRY  = 3,
   parameter int TIMEOUT    = 200,
   parameter int DELAY_UNIT = 100
) (
   input  logic              clock_i2c,
   input  logic              reset,
   input  logic              start,
   output logic [TBL_AW-1:0] tbl_index,
   input  logic [23:0]       tbl_entry,
   output logic [7:0]        slave_address,
   output logic [7:0]        slave_register,
   output logic [7:0]        slave_data,
   output logic              enable_send,
   input  logic              i2c_busy,
   input  logic [7:0]        i2c_status,
   output logic              seq_busy,
   output logic              seq_done,
   output logic              seq_error,
   output logic [TBL_AW-1:0] fail_index,
   output logic [7:0]        fail_status
);

   localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
`ifdef I2C_SEQ_DELAY_EN
   localparam int CNT_W = 24;
`else
   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
`endif

   if (TIMEOUT < 1 || DELAY_UNIT < 1) begin : g_bad_param
      $error("i2c_init_sequencer: TIMEOUT and DELAY_UNIT must be at least 1");
   end

   seq_state_e        state_q, state_d;
   logic [TBL_AW-1:0] tbl_index_q, tbl_index_d;
   logic [7:0]        slave_address_q, slave_address_d;
   logic [7:0]        slave_register_q, slave_register_d;
   logic [7:0]        slave_data_q, slave_data_d;
   logic              enable_send_q, enable_send_d;
   logic              seq_busy_q, seq_busy_d;
   logic              seq_done_q, seq_done_d;
   logic              seq_error_q, seq_error_d;
   logic [TBL_AW-1:0] fail_index_q, fail_index_d;
   logic [7:0]        fail_status_q, fail_status_d;
   logic [RW-1:0]     retry_q, retry_d;

   logic              tmr_load, tmr_dec, tmr_zero;
   logic [CNT_W-1:0]  tmr_val;

   i2c_seq_timer #(.CW(CNT_W)) u_timer (
      .clock_i2c (clock_i2c),
      .reset     (reset),
      .load      (tmr_load),
      .load_val  (tmr_val),
      .dec       (tmr_dec),
      .zero      (tmr_zero)
   );

   always_comb begin
      state_d          = state_q;
      tbl_index_d      = tbl_index_q;
      slave_address_d  = slave_address_q;
      slave_register_d = slave_register_q;
      slave_data_d     = slave_data_q;
      enable_send_d    = enable_send_q;
      seq_busy_d       = seq_busy_q;
      seq_done_d       = seq_done_q;
      seq_error_d      = seq_error_q;
      fail_index_d     = fail_index_q;
      fail_status_d    = fail_status_q;
      retry_d          = retry_q;
      tmr_load         = 1'b0;
      tmr_dec          = 1'b0;
      // Loading TIMEOUT-1 and expiring at zero gives exactly TIMEOUT cycles per wait.
      tmr_val          = CNT_W'(TIMEOUT - 1);

      unique case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               tbl_index_d = '0;
               seq_done_d  = 1'b0;
               seq_error_d = 1'b0;
               retry_d     = '0;
               seq_busy_d  = 1'b1;
               state_d     = S_FETCH;
            end
         end
         S_FETCH: state_d = S_LOAD;
         S_LOAD: begin
            if (tbl_entry[23:16] == END_MARK) begin
               seq_done_d    = 1'b1;
               seq_busy_d    = 1'b0;
               enable_send_d = 1'b1;
               state_d       = S_DONE;
            end
`ifdef I2C_SEQ_DELAY_EN
            else if (tbl_entry[23:16] == DELAY_MARK) begin
               if (tbl_entry[7:0] == 8'h00) begin
                  state_d = S_NEXT;
               end else begin
                  tmr_load = 1'b1;
                  tmr_val  = CNT_W'(tbl_entry[7:0]) * CNT_W'(DELAY_UNIT) - CNT_W'(1);
                  state_d  = S_DELAY;
               end
            end
`endif
            else begin
               slave_address_d  = tbl_entry[23:16];
               slave_register_d = tbl_entry[15:8];
               slave_data_d     = tbl_entry[7:0];
               state_d          = S_REQ;
            end
         end
         S_REQ: begin
            enable_send_d = 1'b0;
            tmr_load      = 1'b1;
            state_d       = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (i2c_busy == I2C_BUSY) begin
               tmr_load = 1'b1;
               state_d  = S_WAIT_DONE;
            end else if (tmr_zero) begin
               seq_error_d   = 1'b1;
               seq_busy_d    = 1'b0;
               enable_send_d = 1'b1;
               fail_index_d  = tbl_index_q;
               state_d       = S_ERROR;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         S_WAIT_DONE: begin
            if (i2c_busy == I2C_NOT_BUSY) begin
               fail_status_d = i2c_status;
               state_d       = S_RELEASE;
            end else if (tmr_zero) begin
               seq_error_d   = 1'b1;
               seq_busy_d    = 1'b0;
               enable_send_d = 1'b1;
               fail_index_d  = tbl_index_q;
               state_d       = S_ERROR;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         S_RELEASE: begin
            enable_send_d = 1'b1;
            state_d       = S_CHECK;
         end
         S_CHECK: begin
            if (is_all_ack(fail_status_q)) begin
               retry_d     = '0;
               tbl_index_d = tbl_index_q + TBL_AW'(1);
               state_d     = S_FETCH;
            end else if (retry_q < RW'(MAX_RETRY)) begin
               retry_d = retry_q + RW'(1);
               state_d = S_FETCH;
            end else begin
               seq_error_d  = 1'b1;
               seq_busy_d   = 1'b0;
               fail_index_d = tbl_index_q;
               state_d      = S_ERROR;
            end
         end
`ifdef I2C_SEQ_DELAY_EN
         S_DELAY: begin
            if (tmr_zero) state_d = S_NEXT;
            else          tmr_dec = 1'b1;
         end
         S_NEXT: begin
            tbl_index_d = tbl_index_q + TBL_AW'(1);
            state_d     = S_FETCH;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock_i2c) begin
      if (!reset) begin
         state_q          <= S_IDLE;
         tbl_index_q      <= '0;
         slave_address_q  <= '0;
         slave_register_q <= '0;
         slave_data_q     <= '0;
         enable_send_q    <= 1'b1;
         seq_busy_q       <= 1'b0;
         seq_done_q       <= 1'b0;
         seq_error_q      <= 1'b0;
         fail_index_q     <= '0;
         fail_status_q    <= '0;
         retry_q          <= '0;
      end else begin
         state_q          <= state_d;
         tbl_index_q      <= tbl_index_d;
         slave_address_q  <= slave_address_d;
         slave_register_q <= slave_register_d;
         slave_data_q     <= slave_data_d;
         enable_send_q    <= enable_send_d;
         seq_busy_q       <= seq_busy_d;
         seq_done_q       <= seq_done_d;
         seq_error_q      <= seq_error_d;
         fail_index_q     <= fail_index_d;
         fail_status_q    <= fail_status_d;
         retry_q          <= retry_d;
      end
   end

   assign tbl_index      = tbl_index_q;
   assign slave_address  = slave_address_q;
   assign slave_register = slave_register_q;
   assign slave_data     = slave_data_q;
   assign enable_send    = enable_send_q;
   assign seq_busy       = seq_busy_q;
   assign seq_done       = seq_done_q;
   assign seq_error      = seq_error_q;
   assign fail_index     = fail_index_q;
   assign fail_status    = fail_status_q;

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Bench for i2c_init_sequencer: table ROM + engine model, directed and randomized sequences.
module tb_i2c_init_sequencer;

   localparam int TBL_AW     = 6;
   localparam int MAX_RETRY  = 3;
   localparam int TIMEOUT    = 200;
   localparam int DELAY_UNIT = 100;

   logic              clock_i2c, reset, start;
   logic [TBL_AW-1:0] tbl_index, fail_index;
   logic [23:0]       tbl_entry;
   logic [7:0]        slave_address, slave_register, slave_data, i2c_status, fail_status;
   logic              enable_send, i2c_busy, seq_busy, seq_done, seq_error;

   i2c_init_sequencer #(.TBL_AW(TBL_AW), .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT),
                        .DELAY_UNIT(DELAY_UNIT)) dut (
      .clock_i2c(clock_i2c), .reset(reset), .start(start), .tbl_index(tbl_index),
      .tbl_entry(tbl_entry), .slave_address(slave_address), .slave_register(slave_register),
      .slave_data(slave_data), .enable_send(enable_send), .i2c_busy(i2c_busy),
      .i2c_status(i2c_status), .seq_busy(seq_busy), .seq_done(seq_done),
      .seq_error(seq_error), .fail_index(fail_index), .fail_status(fail_status)
   );

   int total, bad;
   logic [23:0] tbl [0:63];
   logic [7:0]  stat_q[$];
   logic [23:0] eng_log[$];
   logic [23:0] exp_log[$];
   logic        exp_done, exp_err;
   logic [5:0]  exp_fi;
   logic [7:0]  exp_fs;
   bit          eng_hang, eng_long;
   int          eng_st, eng_cnt;

   initial begin
      clock_i2c = 1'b0;
      forever #5 clock_i2c = ~clock_i2c;
   end

   // Synchronous table ROM: one cycle read latency.
   always @(posedge clock_i2c) tbl_entry <= tbl[tbl_index];

   // Engine model: answers each enable_send request with a busy pulse and a status from stat_q.
   initial begin
      i2c_busy = 1'b1; i2c_status = 8'h00; eng_st = 0; eng_cnt = 0;
      forever begin
         @(negedge clock_i2c);
         if (!reset) begin
            eng_st = 0; i2c_busy = 1'b1;
         end else begin
            case (eng_st)
               0: if (enable_send === 1'b0 && !eng_hang) begin
                  eng_log.push_back({slave_address, slave_register, slave_data});
                  eng_cnt = $urandom_range(0, 3); eng_st = 1;
               end
               1: if (eng_cnt == 0) begin
                  i2c_busy = 1'b0; eng_cnt = eng_long ? 40 : $urandom_range(1, 5); eng_st = 2;
               end else eng_cnt--;
               2: if (eng_cnt == 0) begin
                  i2c_busy = 1'b1;
                  i2c_status = (stat_q.size() > 0) ? stat_q.pop_front() : 8'h2A;
                  eng_st = 3;
               end else eng_cnt--;
               default: if (enable_send === 1'b1) eng_st = 0;
            endcase
         end
      end
   end

   // Reference: walk the table by the documented rules, consuming one status per issued write.
   task automatic model();
      logic [5:0] idx; int retry, k; logic [23:0] e; logic [7:0] st;
      exp_log.delete(); exp_done = 0; exp_err = 0; exp_fi = 0; exp_fs = 0;
      idx = 0; retry = 0; k = 0;
      for (int g = 0; g < 500; g++) begin
         e = tbl[idx];
         if (e[23:16] == 8'hFF) begin exp_done = 1; break; end
`ifdef I2C_SEQ_DELAY_EN
         if (e[23:16] == 8'hFE) begin idx++; continue; end
`endif
         exp_log.push_back(e);
         st = (k < stat_q.size()) ? stat_q[k] : 8'h2A; k++;
         if (st == 8'h2A) begin idx++; retry = 0; end
         else if (retry < MAX_RETRY) retry++;
         else begin exp_err = 1; exp_fi = idx; exp_fs = st; break; end
      end
   endtask

   task automatic run_seq(output bit to);
      @(negedge clock_i2c); start = 1'b1;
      @(negedge clock_i2c); start = 1'b0;
      to = 1'b1;
      for (int c = 0; c < 20000; c++) begin
         @(negedge clock_i2c);
         if (!seq_busy && (seq_done || seq_error)) begin to = 1'b0; break; end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0;
      repeat (3) @(negedge clock_i2c);
      total++; if (enable_send !== 1'b1) begin bad++; $display("FAIL reset_en: got %b want 1", enable_send); end
      total++; if (tbl_index !== '0) begin bad++; $display("FAIL reset_idx: got %0d want 0", tbl_index); end
      total++; if ({slave_address, slave_register, slave_data} !== 24'h0) begin bad++;
         $display("FAIL reset_slave: got %h want 000000", {slave_address, slave_register, slave_data}); end
      total++; if ({seq_busy, seq_done, seq_error} !== 3'b000) begin bad++;
         $display("FAIL reset_flags: got %b want 000", {seq_busy, seq_done, seq_error}); end
      total++; if (fail_index !== '0 || fail_status !== 8'h00) begin bad++;
         $display("FAIL reset_fail: got %0d/%h want 0/00", fail_index, fail_status); end
      reset = 1'b1;
      repeat (3) @(negedge clock_i2c);
      total++; if (seq_busy !== 1'b0 || enable_send !== 1'b1) begin bad++;
         $display("FAIL idle_hold: busy %b en %b want 0 1", seq_busy, enable_send); end
   endtask

   task automatic test_basic();
      bit to;
      tbl[0] = 24'h42_10_A5; tbl[1] = 24'h42_11_5A; tbl[2] = 24'h1C_03_7F; tbl[3] = 24'hFF_00_00;
      stat_q.delete(); eng_log.delete();
      run_seq(to);
      total++; if (to) begin bad++; $display("FAIL basic_term: no done/error"); end
      total++; if (eng_log.size() != 3) begin bad++; $display("FAIL basic_cnt: got %0d want 3", eng_log.size()); end
      else for (int i = 0; i < 3; i++) begin
         total++; if (eng_log[i] !== tbl[i]) begin bad++;
            $display("FAIL basic_xfer%0d: got %h want %h", i, eng_log[i], tbl[i]); end
      end
      total++; if ({seq_done, seq_error} !== 2'b10) begin bad++;
         $display("FAIL basic_flags: done/err %b want 10", {seq_done, seq_error}); end
   endtask

   task automatic test_retry();
      bit to; logic [23:0] want [5];
      tbl[0] = 24'h30_01_02; tbl[1] = 24'h30_02_03; tbl[2] = 24'h30_03_04; tbl[3] = 24'hFF_00_00;
      stat_q = '{8'h2A, 8'h29, 8'h29, 8'h2A, 8'h2A};
      want = '{24'h30_01_02, 24'h30_02_03, 24'h30_02_03, 24'h30_02_03, 24'h30_03_04};
      eng_log.delete();
      run_seq(to);
      total++; if (to) begin bad++; $display("FAIL retry_term: no done/error"); end
      total++; if (eng_log.size() != 5) begin bad++; $display("FAIL retry_cnt: got %0d want 5", eng_log.size()); end
      else for (int i = 0; i < 5; i++) begin
         total++; if (eng_log[i] !== want[i]) begin bad++;
            $display("FAIL retry_xfer%0d: got %h want %h", i, eng_log[i], want[i]); end
      end
      total++; if ({seq_done, seq_error} !== 2'b10) begin bad++;
         $display("FAIL retry_flags: done/err %b want 10", {seq_done, seq_error}); end
   endtask

   task automatic test_nack_exhaust();
      bit to;
      tbl[0] = 24'h50_AA_BB; tbl[1] = 24'hFF_00_00;
      stat_q = '{8'h15, 8'h15, 8'h15, 8'h15, 8'h15, 8'h15};
      eng_log.delete();
      run_seq(to);
      total++; if (to) begin bad++; $display("FAIL nack_term: no done/error"); end
      total++; if (eng_log.size() != MAX_RETRY + 1) begin bad++;
         $display("FAIL nack_cnt: got %0d want %0d", eng_log.size(), MAX_RETRY + 1); end
      total++; if ({seq_done, seq_error, seq_busy} !== 3'b010) begin bad++;
         $display("FAIL nack_flags: done/err/busy %b want 010", {seq_done, seq_error, seq_busy}); end
      total++; if (fail_index !== 6'd0 || fail_status !== 8'h15) begin bad++;
         $display("FAIL nack_fail: got %0d/%h want 0/15", fail_index, fail_status); end
      stat_q.delete();
   endtask

   task automatic test_timeout();
      int low; bit seen;
      tbl[0] = 24'h60_01_01; tbl[1] = 24'hFF_00_00;
      eng_hang = 1'b1; eng_log.delete(); low = 0; seen = 0;
      @(negedge clock_i2c); start = 1'b1;
      @(negedge clock_i2c); start = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         @(negedge clock_i2c);
         if (enable_send === 1'b0) low++;
         if (seq_error === 1'b1) begin seen = 1; break; end
      end
      total++; if (!seen) begin bad++; $display("FAIL tmo_term: seq_error never set"); end
      total++; if (low != TIMEOUT) begin bad++; $display("FAIL tmo_len: enable low %0d want %0d", low, TIMEOUT); end
      total++; if (enable_send !== 1'b1 || seq_busy !== 1'b0) begin bad++;
         $display("FAIL tmo_release: en %b busy %b want 1 0", enable_send, seq_busy); end
      total++; if (fail_index !== 6'd0) begin bad++; $display("FAIL tmo_idx: got %0d want 0", fail_index); end
      eng_hang = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit to, hit;
      tbl[0] = 24'h70_00_11; tbl[1] = 24'h71_01_22; tbl[2] = 24'h72_02_33; tbl[3] = 24'hFF_00_00;
      stat_q.delete(); eng_log.delete(); eng_long = 1'b1; hit = 0;
      @(negedge clock_i2c); start = 1'b1;
      @(negedge clock_i2c); start = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clock_i2c);
         if (eng_log.size() == 2 && i2c_busy === 1'b0) begin hit = 1; break; end
      end
      @(negedge clock_i2c);
      total++; if (!hit || tbl_index !== 6'd1 || enable_send !== 1'b0) begin bad++;
         $display("FAIL rmid_pre: hit %0d idx %0d en %b want 1 1 0", hit, tbl_index, enable_send); end
      reset = 1'b0;
      @(negedge clock_i2c);
      total++; if (enable_send !== 1'b1 || seq_busy !== 1'b0 || tbl_index !== '0) begin bad++;
         $display("FAIL rmid_post: en %b busy %b idx %0d want 1 0 0", enable_send, seq_busy, tbl_index); end
      total++; if ({slave_address, slave_register, slave_data} !== 24'h0 || seq_done !== 1'b0) begin bad++;
         $display("FAIL rmid_slave: got %h done %b want 000000 0", {slave_address, slave_register, slave_data}, seq_done); end
      repeat (2) @(negedge clock_i2c);
      reset = 1'b1; eng_long = 1'b0; eng_log.delete();
      run_seq(to);
      total++; if (to || eng_log.size() != 3) begin bad++;
         $display("FAIL rmid_restart: to %0d cnt %0d want 0 3", to, eng_log.size()); end
      else begin
         total++; if (eng_log[0] !== tbl[0]) begin bad++;
            $display("FAIL rmid_first: got %h want %h", eng_log[0], tbl[0]); end
      end
   endtask

   task automatic test_random();
      bit to; int len; logic [7:0] s; logic [23:0] e;
      for (int it = 0; it < 12; it++) begin
         len = $urandom_range(1, 6);
         for (int i = 0; i < len; i++) begin
            e[23:16] = 8'($urandom_range(0, 253)); e[15:0] = 16'($urandom());
            tbl[i] = e;
         end
         tbl[len] = 24'hFF_00_00;
         stat_q.delete();
         for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) begin
               s = 8'($urandom()); if (s == 8'h2A) s = 8'h15;
            end else s = 8'h2A;
            stat_q.push_back(s);
         end
         model();
         eng_log.delete();
         run_seq(to);
         total++; if (to) begin bad++; $display("FAIL rand%0d_term: no done/error", it); end
         total++; if (eng_log.size() != exp_log.size()) begin bad++;
            $display("FAIL rand%0d_cnt: got %0d want %0d", it, eng_log.size(), exp_log.size()); end
         else for (int i = 0; i < exp_log.size(); i++) begin
            total++; if (eng_log[i] !== exp_log[i]) begin bad++;
               $display("FAIL rand%0d_xfer%0d: got %h want %h", it, i, eng_log[i], exp_log[i]); end
         end
         total++; if ({seq_done, seq_error} !== {exp_done, exp_err}) begin bad++;
            $display("FAIL rand%0d_flags: got %b want %b", it, {seq_done, seq_error}, {exp_done, exp_err}); end
         if (exp_err) begin
            total++; if (fail_index !== exp_fi || fail_status !== exp_fs) begin bad++;
               $display("FAIL rand%0d_fail: got %0d/%h want %0d/%h", it, fail_index, fail_status, exp_fi, exp_fs); end
         end
      end
      stat_q.delete();
   endtask

`ifdef I2C_SEQ_DELAY_EN
   task automatic test_delay();
      int gap; bit seen;
      for (int pass = 0; pass < 2; pass++) begin
         tbl[0] = (pass == 0) ? 24'hFE_00_03 : 24'hFE_00_00;
         tbl[1] = 24'h11_22_33; tbl[2] = 24'hFF_00_00;
         eng_log.delete(); gap = 0; seen = 0;
         @(negedge clock_i2c); start = 1'b1;
         @(negedge clock_i2c); start = 1'b0;
         for (int c = 0; c < 2000; c++) begin
            gap++;
            @(negedge clock_i2c);
            if (enable_send === 1'b0) begin seen = 1; break; end
         end
         total++; if (!seen || (pass == 0 && (gap < 300 || gap > 312)) || (pass == 1 && gap > 12)) begin bad++;
            $display("FAIL delay%0d_gap: seen %0d gap %0d", pass, seen, gap); end
         for (int c = 0; c < 2000 && !(seq_done || seq_error); c++) @(negedge clock_i2c);
         total++; if (eng_log.size() != 1 || seq_done !== 1'b1) begin bad++;
            $display("FAIL delay%0d_end: cnt %0d done %b want 1 1", pass, eng_log.size(), seq_done); end
         else begin
            total++; if (eng_log[0] !== 24'h11_22_33) begin bad++;
               $display("FAIL delay%0d_xfer: got %h want 112233", pass, eng_log[0]); end
         end
      end
   endtask
`else
   task automatic test_fe_plain();
      bit to;
      tbl[0] = 24'hFE_12_34; tbl[1] = 24'hFF_00_00;
      stat_q.delete(); eng_log.delete();
      run_seq(to);
      total++; if (to || eng_log.size() != 1) begin bad++;
         $display("FAIL fe_cnt: to %0d cnt %0d want 0 1", to, eng_log.size()); end
      else begin
         total++; if (eng_log[0] !== 24'hFE_12_34) begin bad++;
            $display("FAIL fe_xfer: got %h want fe1234", eng_log[0]); end
      end
   endtask
`endif

   initial begin
      total = 0; bad = 0; eng_hang = 1'b0; eng_long = 1'b0;
      reset = 1'b0; start = 1'b0;
      for (int i = 0; i < 64; i++) tbl[i] = 24'hFF_00_00;
      test_reset();
      test_basic();
      test_retry();
      test_nack_exhaust();
      test_timeout();
      test_reset_mid();
      test_random();
`ifdef I2C_SEQ_DELAY_EN
      test_delay();
`else
      test_fe_plain();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
